skinny_sbox_layer_sched: RTL and testbench

- Sequences one full SubCells layer (16 bytes) of a 2-share masked SKINNY-128 state through a single shared, non-pipelined masked 8-bit S-box instance.
- Feeds the S-box one byte per call, together with fresh randomness taken through a valid/ready handshake from the PRNG.
- Captures the output shares and writes them back into the internal state share registers.
- Sits between the round controller / state registers and the external masked S-box (2 shares in/out, 76 random bits, fixed latency).

---
 rtl/skinny_sbox_layer_sched.sv | 212 +++++++++++++++++++++
 tb/tb_skinny_sbox_layer_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox_layer_sched.sv
// skinny_sbox_layer_sched
//
// Runs one SubCells layer (16 bytes) of a 2-share masked SKINNY-128 state through
// a single shared, non-pipelined masked 8-bit S-box. Each byte takes one ISSUE cycle,
// which waits for fresh randomness from the PRNG, plus SBOX_LAT WAIT cycles. The
// output shares are then written back into the internal share registers.
// The two shares are never combined anywhere in this block.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a layer (sampled only while idle)
//   st_in_0/1   [127:0]   input state shares; byte i = bits [8i+7:8i]
//   busy                  high while bytes are being issued or waited on
//   done                  one-cycle pulse; st_out_0/1 are valid from then on
//   st_out_0/1  [127:0]   substituted shares, held until the next layer completes
//   rnd [RW-1:0], rnd_valid, rnd_ready   PRNG handshake
//   sb_si_0/1   [7:0]     registered S-box input shares
//   sb_r        [75:0]    registered S-box randomness
//   sb_so_0/1   [7:0]     S-box output shares
//
// Optional build macro SKINNY_SCHED_REMASK_EN: widens rnd to 84 bits. rnd[83:76]
// becomes a refresh mask m that is XORed into both output shares on capture.

module skinny_sbox_layer_sched #(
  parameter int unsigned SBOX_LAT = 2,
`ifdef SKINNY_SCHED_REMASK_EN
  localparam int unsigned RW = 84
`else
  localparam int unsigned RW = 76
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  st_in_0,
  input  logic [127:0]  st_in_1,
  output logic          busy,
  output logic          done,
  output logic [127:0]  st_out_0,
  output logic [127:0]  st_out_1,
  input  logic [RW-1:0] rnd,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic [7:0]    sb_si_0,
  output logic [7:0]    sb_si_1,
  output logic [75:0]   sb_r,
  input  logic [7:0]    sb_so_0,
  input  logic [7:0]    sb_so_1
);

  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [127:0]   sh0_q, sh0_d, sh1_q, sh1_d;
  logic [3:0]     idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]     si0_q, si0_d, si1_q, si1_d;
  logic [75:0]    sbr_q, sbr_d;
  logic           done_q, done_d;
  logic [127:0]   out0_q, out0_d, out1_q, out1_d;
  logic [7:0]     cap0, cap1;
  logic [6:0]     bsel;

  assign bsel = {idx_q, 3'b000};

`ifdef SKINNY_SCHED_REMASK_EN
  logic [7:0] m_q, m_d;

  // The same mask on both shares leaves the unshared value unchanged.
  always_comb begin
    cap0 = sb_so_0 ^ m_q;
    cap1 = sb_so_1 ^ m_q;
  end
`else
  always_comb begin
    cap0 = sb_so_0;
    cap1 = sb_so_1;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (rnd_valid) state_d = StWait;
      StWait: begin
        if (cnt_q == '0) state_d = (idx_q == 4'd15) ? StDone : StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = 1'b0;
    rnd_ready = 1'b0;
    unique case (state_q)
      StIssue: begin
        busy      = 1'b1;
        rnd_ready = 1'b1;
      end
      StWait:  busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    si0_d  = si0_q;
    si1_d  = si1_q;
    sbr_d  = sbr_q;
    done_d = 1'b0;
    out0_d = out0_q;
    out1_d = out1_q;
`ifdef SKINNY_SCHED_REMASK_EN
    m_d    = m_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh0_d = st_in_0;
          sh1_d = st_in_1;
          idx_d = 4'd0;
        end
      end
      StIssue: begin
        // sb_* only move on an accepted handshake, so every byte gets its own randomness.
        if (rnd_valid) begin
          si0_d = sh0_q[bsel +: 8];
          si1_d = sh1_q[bsel +: 8];
          sbr_d = rnd[75:0];
`ifdef SKINNY_SCHED_REMASK_EN
          m_d   = rnd[83:76];
`endif
          cnt_d = CntW'(SBOX_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sh0_d[bsel +: 8] = cap0;
          sh1_d[bsel +: 8] = cap1;
          if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
        end
      end
      StDone: begin
        done_d = 1'b1;
        out0_d = sh0_q;
        out1_d = sh1_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_q  <= '0;
      sh1_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      si0_q  <= '0;
      si1_q  <= '0;
      sbr_q  <= '0;
      done_q <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
`ifdef SKINNY_SCHED_REMASK_EN
      m_q    <= '0;
`endif
    end else begin
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      si0_q  <= si0_d;
      si1_q  <= si1_d;
      sbr_q  <= sbr_d;
      done_q <= done_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
`ifdef SKINNY_SCHED_REMASK_EN
      m_q    <= m_d;
`endif
    end
  end

  assign done     = done_q;
  assign st_out_0 = out0_q;
  assign st_out_1 = out1_q;
  assign sb_si_0  = si0_q;
  assign sb_si_1  = si1_q;
  assign sb_r     = sbr_q;

endmodule

// File: tb/tb_skinny_sbox_layer_sched.sv
// Scoreboard bench for skinny_sbox_layer_sched with a behavioural masked S-box
// (SBOX_LAT = 2). Stimulus pushes the expected layer result at start; a negedge
// monitor pops and compares on every done pulse.

module tb_skinny_sbox_layer_sched;

  localparam int unsigned LAT = 2;
`ifdef SKINNY_SCHED_REMASK_EN
  localparam int unsigned RW = 84;
  localparam logic [7:0]  M  = 8'hA5;
`else
  localparam int unsigned RW = 76;
  localparam logic [7:0]  M  = 8'h00;
`endif

  localparam logic [127:0] U1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] U2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  // SKINNY-128 8-bit S-box, row r holds S(16r .. 16r+15) from the MSB down.
  localparam logic [127:0] SROW [16] = '{
    128'h654c6a42_4b63436b_55755a7a_53735b7b,
    128'h358c3a81_8933803b_9525982a_9023992b,
    128'he5cce8c1_c9e0c0e9_d5f5d8f8_d0f0d9f9,
    128'ha51ca812_1ba013a9_05b50ab8_03b00bb9,
    128'h32883c85_8d34843d_91229c2c_94249d2d,
    128'h624a6c45_4d64446d_52725c7c_54745d7d,
    128'ha11aac15_1da414ad_02b10cbc_04b40dbd,
    128'he1c8ecc5_cde4c4ed_d1f1dcfc_d4f4ddfd,
    128'h368e3882_8b308339_96269a28_93209b29,
    128'h664e6841_49604069_56765878_50705979,
    128'ha61eaa11_19a310ab_06b608ba_00b309bb,
    128'he6ceeac2_cbe3c3eb_d6f6dafa_d3f3dbfb,
    128'h318a3e86_8f37873f_92219e2e_97279f2f,
    128'h61486e46_4f67476f_51715e7e_57775f7f,
    128'ha218ae16_1fa717af_01b20ebe_07b70fbf,
    128'he2caeec6_cfe7c7ef_d2f2defe_d7f7dfff
  };

  typedef struct {
    logic [127:0] u;
    int unsigned  g0;
    int           t0;
    int           lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start;
  logic [127:0]  st_in_0, st_in_1;
  logic          busy, done;
  logic [127:0]  st_out_0, st_out_1;
  logic [RW-1:0] rnd;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [7:0]    sb_si_0, sb_si_1;
  logic [75:0]   sb_r;
  logic [7:0]    sb_so_0, sb_so_1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc = 0;
  int unsigned hs_g = 0;
  int unsigned g0_cur = 0;
  logic [127:0] cur_u = '0;
  logic [75:0]  exp_sbr = '0;
  logic [7:0]   exp_si = '0;
  logic [7:0]   md_x = '0;
  logic [7:0]   md_r = '0;
  exp_t         exp_q[$];

  skinny_sbox_layer_sched #(.SBOX_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .st_in_0   (st_in_0),
    .st_in_1   (st_in_1),
    .busy      (busy),
    .done      (done),
    .st_out_0  (st_out_0),
    .st_out_1  (st_out_1),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .sb_si_0   (sb_si_0),
    .sb_si_1   (sb_si_1),
    .sb_r      (sb_r),
    .sb_so_0   (sb_so_0),
    .sb_so_1   (sb_so_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    int sh;
    row = SROW[x[7:4]];
    sh  = 8 * (15 - int'(x[3:0]));
    return row[sh +: 8];
  endfunction

  function automatic logic [7:0] mask_of(input int unsigned g);
    return 8'(g * 37 + 11);
  endfunction

  function automatic logic [RW-1:0] mk_rnd(input int unsigned g);
    logic [75:0] r;
    r = {36'd0, 32'(g), mask_of(g)};
`ifdef SKINNY_SCHED_REMASK_EN
    return {M, r};
`else
    return r;
`endif
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int unsigned i);
    return v[8 * i[3:0] +: 8];
  endfunction

  // PRNG: a counter, so every accepted word is distinct.
  assign rnd = mk_rnd(hs_g);

  // Masked S-box model: one register stage, so its output settles LAT-1 cycles after
  // the registered inputs change and is sampled on the LAT-th edge.
  always @(posedge clk) begin
    md_x <= sb_si_0 ^ sb_si_1;
    md_r <= sb_r[7:0];
  end
  assign sb_so_0 = sbox(md_x) ^ md_r;
  assign sb_so_1 = md_r;

  // Handshake tracker: expected registered S-box inputs after each accepted word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sbr <= '0;
      exp_si  <= '0;
    end else if (rnd_valid && rnd_ready) begin
      hs_g    <= hs_g + 1;
      exp_sbr <= rnd[75:0];
      exp_si  <= byte_of(cur_u, hs_g - g0_cur);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] ub, mb;
    if (!rst_n) begin
      check("rst_st_out", st_out_0 | st_out_1, '0);
      check("rst_ctrl", 128'({busy, done, rnd_ready, sb_si_0, sb_si_1}), '0);
      check("rst_sb_r", 128'(sb_r), '0);
      exp_q.delete();
    end else begin
      if (busy) begin
        check("sb_r_held", 128'(sb_r), 128'(exp_sbr));
        check("sb_si", 128'(sb_si_0 ^ sb_si_1), 128'(exp_si));
      end
      if (done) begin
        n_done++;
        check("busy_at_done", 128'(busy), '0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 128'(done), '0);
        end else begin
          e = exp_q.pop_front();
          check("latency", 128'(cyc - e.t0), 128'(e.lat));
          check("hs_count", 128'(hs_g - e.g0), 128'd16);
          for (int i = 0; i < 16; i++) begin
            ub = byte_of(e.u, i);
            mb = mask_of(e.g0 + i) ^ M;
            check($sformatf("share0_byte%0d", i), 128'(byte_of(st_out_0, i)),
                  128'(sbox(ub) ^ mb));
            check($sformatf("share1_byte%0d", i), 128'(byte_of(st_out_1, i)), 128'(mb));
          end
        end
      end
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_start(input logic [127:0] s0, input logic [127:0] s1, input int extra);
    exp_t e;
    @(negedge clk);
    st_in_0 = s0;
    st_in_1 = s1;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cur_u  = s0 ^ s1;
    g0_cur = hs_g;
    e.u    = cur_u;
    e.g0   = hs_g;
    e.t0   = cyc;
    e.lat  = 16 * (1 + LAT) + 1 + extra;
    exp_q.push_back(e);
    check("busy_after_start", 128'(busy), 128'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("done_timeout", 128'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] a;
    int d0;
    start     = 1'b0;
    st_in_0   = '0;
    st_in_1   = '0;
    rnd_valid = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 128'({busy, done, rnd_ready}), '0);
    check("idle_st_out", st_out_0 | st_out_1, '0);

    // Plain layer, randomness always available
    a = rand128();
    do_start(a, a ^ U1, 0);
    wait_done();

    // PRNG stall of 5 cycles at byte 7
    a = rand128();
    do_start(a, a ^ U1, 5);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rnd_ready && (hs_g - g0_cur == 7)) break;
    end
    rnd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rnd_valid = 1'b1;
    wait_done();

    // Start pulse at cycle 10 of a running layer must be ignored
    d0 = n_done;
    a = rand128();
    do_start(a, a ^ U2, 0);
    repeat (9) @(negedge clk);
    st_in_0 = rand128();
    st_in_1 = rand128();
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);
    check("single_done", 128'(n_done - d0), 128'd1);

    // Reset at cycle 20 aborts the layer; a fresh layer then completes
    a = rand128();
    do_start(a, a ^ U1, 0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_st_out", st_out_0 | st_out_1, '0);
    check("post_rst_busy", 128'(busy), '0);
    a = rand128();
    do_start(a, a ^ U2, 0);
    wait_done();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
